blocking_port_arbiter: RTL
==========================

# blocking_port_arbiter

Two-to-one arbiter that shares a single blocking output port between two blocking requester ports. It uses round-robin priority and a two-section control FSM. Each accepted word is forwarded downstream. On completion the word is published on a master/slave shared-variable output, `s_out`, and a transfer counter is incremented. The block sits between two producer modules and one consumer module in the generated master/slave test designs.

## Interface

Parameters:
- DATA_W, 32: width of data words (signed integer semantics).
- CNT_W, 8: width of the transfer counter.
- S_OUT_INIT, 1337: reset value of `s_out`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_sig  in  DATA_W  requester 0 data.
- req0_sync  in  1  requester 0 has a valid word.
- req0_notify  out  1  one-cycle acknowledge that requester 0's word was taken.
- req1_sig  in  DATA_W  requester 1 data.
- req1_sync  in  1  requester 1 has a valid word.
- req1_notify  out  1  one-cycle acknowledge that requester 1's word was taken.
- out_sig  out  DATA_W  forwarded word.
- out_notify  out  1  `out_sig` valid, held until the consumer takes it.
- out_sync  in  1  consumer ready.
- s_out  out  DATA_W  last word delivered downstream (shared variable).
- grant_id  out  1  index of the requester owning the current or last transfer.
- xfer_count  out  CNT_W  number of completed downstream transfers.

## Operation

- Sections: `section_idle`, `section_fwd`. Reset section is `section_idle`.
- Reset values:
  - `req0_notify` = `req1_notify` = `out_notify` = 0.
  - `out_sig` = 0.
  - `s_out` = S_OUT_INIT.
  - `grant_id` = 1, so requester 0 wins the first contention.
  - `xfer_count` = 0.
- `section_idle`, on an edge where some `reqN_sync` = 1:
  - Select requester: if only one syncs, pick it. If both sync, pick the index ≠ `grant_id`.
  - `out_sig` <= that requester's `reqN_sig`.
  - `grant_id` <= the selected index.
  - `reqN_notify` <= 1 for the winner only.
  - `out_notify` <= 1.
  - Go to `section_fwd`.
- `section_idle` with no sync: hold all state; notifies stay 0.
- `section_fwd`:
  - `reqN_notify` <= 0, so the acknowledge is exactly one cycle wide.
  - Requester `sync` inputs are ignored; the loser keeps waiting.
  - On an edge with `out_sync` = 1: `out_notify` <= 0, `s_out` <= `out_sig`, `xfer_count` <= `xfer_count` + 1 (modulo 2^CNT_W, 255 wraps to 0), then go to `section_idle`.
  - With `out_sync` = 0: hold `out_sig` and `out_notify` stable.
- Requesters must deassert `sync` in the cycle after they see `notify`. A `sync` still high when returning to `section_idle` is treated as a new word.
- Data passes through unmodified; no arithmetic is applied.

## Timing

- Request to `out_notify`: 1 cycle (registered).
- `out_sync` high to `s_out` updated: 1 cycle.
- Back-to-back throughput: one transfer per 2 cycles with `out_sync` tied high.
- Simultaneous `sync` on both requesters: strict alternation, since every grant flips priority.
- `out_sync` may be high before `out_notify`. It is only sampled in `section_fwd`.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). The in-flight word is dropped and `xfer_count` is not incremented.
- No combinational path from any input to any output.

## Structure

- Shared package `blockingportarbiter_types`:
  - `Sections` enum {`section_idle`, `section_fwd`}.
  - `S_OUT_INIT_DEFAULT` = 1337.
- Top-level design types (integer width) come from the `top_level_types` package.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin selector.
  - Inputs: `sync0`, `sync1`, `last`.
  - Outputs: `valid`, `idx`.
- All state lives in a single `always_ff` in the top module.

## Test plan

- **Reset check**: assert rst → `s_out` = 1337, `xfer_count` = 0, all notifies 0, `grant_id` = 1.
- **Single requester**: `req0_sig` = 42 with `req0_sync` for one cycle; `out_sync` = 1 → `req0_notify` pulses once, `out_sig` = 42 one cycle later, then `s_out` = 42, `xfer_count` = 1.
- **Contention**: both sync continuously; `req0_sig` = 10, `req1_sig` = 20; `out_sync` = 1 → delivered sequence 10, 20, 10, 20, one transfer every 2 cycles.
- **Backpressure**: hold `out_sync` = 0 for 5 cycles after a grant → `out_notify` and `out_sig` stable, no new acknowledges. Then raise `out_sync` → single completion.
- **Counter wrap**: 256 transfers → `xfer_count` returns to 0, and `s_out` equals the last word.
- **Reset during `section_fwd`**: pulse rst while `out_notify` = 1 → outputs return to reset values, no count increment, and the next request is served normally.

Source files
------------

// File: rtl/blocking_port_arbiter_pkg.sv
// Type and constant packages shared by the blocking port arbiter slice.
package top_level_types;
   localparam int INT_W = 32;
endpackage

package blockingportarbiter_types;
   typedef enum logic [0:0] {
      section_idle = 1'b0,
      section_fwd  = 1'b1
   } Sections;

   localparam int S_OUT_INIT_DEFAULT = 1337;
endpackage

// File: rtl/blocking_port_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the index that did not win last time is chosen.
module rr_pick2 (
   input  logic sync0,
   input  logic sync1,
   input  logic last,
   output logic valid,
   output logic idx
);

   // Winner selection; a lone requester always wins regardless of priority.
   always_comb begin
      valid = sync0 | sync1;
      if (sync0 && sync1) begin
         idx = ~last;
      end else if (sync1) begin
         idx = 1'b1;
      end else begin
         idx = 1'b0;
      end
   end

endmodule

// File: rtl/blocking_port_arbiter.sv
// Shares one blocking output port between two blocking requesters with round-robin priority.
module blocking_port_arbiter
   import blockingportarbiter_types::*;
#(
   parameter int DATA_W     = top_level_types::INT_W,
   parameter int CNT_W      = 8,
   parameter int S_OUT_INIT = S_OUT_INIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] req0_sig,
   input  logic              req0_sync,
   output logic              req0_notify,
   input  logic [DATA_W-1:0] req1_sig,
   input  logic              req1_sync,
   output logic              req1_notify,
   output logic [DATA_W-1:0] out_sig,
   output logic              out_notify,
   input  logic              out_sync,
   output logic [DATA_W-1:0] s_out,
   output logic              grant_id,
   output logic [CNT_W-1:0]  xfer_count
);

   Sections             section_q;
   logic                req0_notify_q;
   logic                req1_notify_q;
   logic [DATA_W-1:0]   out_sig_q;
   logic                out_notify_q;
   logic [DATA_W-1:0]   s_out_q;
   logic                grant_id_q;
   logic [CNT_W-1:0]    xfer_count_q;
   logic                pick_valid_s;
   logic                pick_idx_s;

   rr_pick2 u_pick (
      .sync0 (req0_sync),
      .sync1 (req1_sync),
      .last  (grant_id_q),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   // Control FSM and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         section_q     <= section_idle;
         req0_notify_q <= 1'b0;
         req1_notify_q <= 1'b0;
         out_sig_q     <= '0;
         out_notify_q  <= 1'b0;
         s_out_q       <= DATA_W'(S_OUT_INIT);
         grant_id_q    <= 1'b1;
         xfer_count_q  <= '0;
      end else begin
         case (section_q)
            section_idle: begin
               if (pick_valid_s) begin
                  out_sig_q     <= pick_idx_s ? req1_sig : req0_sig;
                  grant_id_q    <= pick_idx_s;
                  req0_notify_q <= ~pick_idx_s;
                  req1_notify_q <= pick_idx_s;
                  out_notify_q  <= 1'b1;
                  section_q     <= section_fwd;
               end else begin
                  req0_notify_q <= 1'b0;
                  req1_notify_q <= 1'b0;
               end
            end
            section_fwd: begin
               // Requester syncs are ignored here; the loser simply keeps waiting.
               req0_notify_q <= 1'b0;
               req1_notify_q <= 1'b0;
               if (out_sync) begin
                  out_notify_q <= 1'b0;
                  s_out_q      <= out_sig_q;
                  xfer_count_q <= xfer_count_q + CNT_W'(1);
                  section_q    <= section_idle;
               end else begin
                  out_notify_q <= 1'b1;
               end
            end
            default: begin
               section_q     <= section_idle;
               req0_notify_q <= 1'b0;
               req1_notify_q <= 1'b0;
               out_notify_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req0_notify = req0_notify_q;
   assign req1_notify = req1_notify_q;
   assign out_sig     = out_sig_q;
   assign out_notify  = out_notify_q;
   assign s_out       = s_out_q;
   assign grant_id    = grant_id_q;
   assign xfer_count  = xfer_count_q;

endmodule
